// File: rtl/fifo_sync_ctrl_pkg.sv
// fifo_ctrl_pkg: constants and helpers shared by the FIFO controller slice.
//   fifo_depth(aw)  : number of array entries for an address width (2**aw)
//   ptr_width(aw)   : pointer width including the wrap bit (aw+1)
//   *_DEF constants : default address width and almost-full/empty levels
package fifo_ctrl_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;
  localparam int unsigned AFULL_LVL_DEF  = 6;
  localparam int unsigned AEMPTY_LVL_DEF = 2;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_ctrl_ptr.sv
// fifo_ptr: wrap-bit pointer register for the FIFO controller.
//   clk  : clock
//   rst  : synchronous active-high reset, clears the pointer
//   inc  : advance the pointer by one this edge
//   ptr  : ADDR_WIDTH+1 bit pointer; MSB is the wrap bit
module fifo_ptr
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  output logic [ADDR_WIDTH:0]   ptr
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);

  // A plain binary increment carries out of the address bits into the
  // wrap bit, so DEPTH-1 -> 0 with the wrap bit toggled comes for free.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl: single-clock controller for a dual-port FIFO storage array
// with 1-cycle registered read and synchronous write.
//   clk, rst          : clock, synchronous active-high reset
//   push, pop         : write / read requests
//   clr_err           : clears sticky overflow / underflow
//   waddr, raddr, wen, ren : array address and enable outputs
//   rvalid            : array read data valid (one cycle after ren)
//   full, empty, almost_full, almost_empty, count : occupancy status
//   overflow, underflow : sticky rejected-push / rejected-pop flags
module fifo_sync_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned AFULL_LVL  = AFULL_LVL_DEF,
  parameter int unsigned AEMPTY_LVL = AEMPTY_LVL_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clr_err,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  wen,
  output logic                  ren,
  output logic                  rvalid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

  if (AFULL_LVL < 1 || AFULL_LVL > DEPTH) begin : g_bad_afull
    $error("fifo_sync_ctrl: AFULL_LVL must be in 1..DEPTH");
  end
  if (AEMPTY_LVL > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync_ctrl: AEMPTY_LVL must be in 0..DEPTH-1");
  end

  logic [ADDR_WIDTH:0] wptr;
  logic [ADDR_WIDTH:0] rptr;

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wptr (
    .clk (clk),
    .rst (rst),
    .inc (wen),
    .ptr (wptr)
  );

  fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rptr (
    .clk (clk),
    .rst (rst),
    .inc (ren),
    .ptr (rptr)
  );

  always_comb begin
    waddr        = wptr[ADDR_WIDTH-1:0];
    raddr        = rptr[ADDR_WIDTH-1:0];
    empty        = (wptr == rptr);
    full         = (wptr[ADDR_WIDTH-1:0] == rptr[ADDR_WIDTH-1:0]) &&
                   (wptr[ADDR_WIDTH] != rptr[ADDR_WIDTH]);
    // Modulo subtraction over the wrap-bit pointers yields 0..DEPTH.
    count        = wptr - rptr;
    almost_full  = (32'(count) >= AFULL_LVL);
    almost_empty = (32'(count) <= AEMPTY_LVL);
    wen          = push & ~full;
    ren          = pop & ~empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      rvalid <= ren;
      // A new error event outranks a simultaneous clear.
      if (push & full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (pop & empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
module tb_fifo_sync_ctrl;

  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst, push, pop, clr_err;
  logic [AW-1:0] waddr, raddr;
  logic          wen, ren, rvalid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  fifo_sync_ctrl #(
    .ADDR_WIDTH (AW),
    .AFULL_LVL  (AF),
    .AEMPTY_LVL (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .clr_err      (clr_err),
    .waddr        (waddr),
    .raddr        (raddr),
    .wen          (wen),
    .ren          (ren),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: occupancy and running totals of accepted transfers.
  int occ   = 0;
  int wr_n  = 0;
  int rd_n  = 0;
  int rv_m  = 0;
  int ovf_m = 0;
  int unf_m = 0;

  typedef struct {
    logic rst, push, pop, clr;
    int   cnt, wa, ra;
    int   wen, ren, rv, full, empty, af, ae, ovf, unf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, p, q, c, input int cnt, wa, ra,
                              input int we, re, rv, fu, em, af, ae, ov, un);
    vec_t v;
    v.rst = r; v.push = p; v.pop = q; v.clr = c;
    v.cnt = cnt; v.wa = wa; v.ra = ra;
    v.wen = we; v.ren = re; v.rv = rv; v.full = fu; v.empty = em;
    v.af = af; v.ae = ae; v.ovf = ov; v.unf = un;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_chk++;
    if (act === 32'(exp)) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic check_model();
    int f, e;
    f = (occ == DEPTH) ? 1 : 0;
    e = (occ == 0) ? 1 : 0;
    chk("m_count",  32'(count),        occ);
    chk("m_waddr",  32'(waddr),        wr_n % DEPTH);
    chk("m_raddr",  32'(raddr),        rd_n % DEPTH);
    chk("m_wen",    32'(wen),          (push && !f) ? 1 : 0);
    chk("m_ren",    32'(ren),          (pop && !e) ? 1 : 0);
    chk("m_rvalid", 32'(rvalid),       rv_m);
    chk("m_full",   32'(full),         f);
    chk("m_empty",  32'(empty),        e);
    chk("m_afull",  32'(almost_full),  (occ >= AF) ? 1 : 0);
    chk("m_aempty", 32'(almost_empty), (occ <= AE) ? 1 : 0);
    chk("m_ovf",    32'(overflow),     ovf_m);
    chk("m_unf",    32'(underflow),    unf_m);
  endtask

  // Drive inputs (called just after a falling edge) and check outputs.
  task automatic apply(input logic r, p, q, c);
    rst = r; push = p; pop = q; clr_err = c;
    #1;
    check_model();
  endtask

  // Cross the rising edge and update the model from the held inputs.
  task automatic advance();
    int w, rd;
    @(posedge clk);
    w  = (push && occ < DEPTH) ? 1 : 0;
    rd = (pop && occ > 0) ? 1 : 0;
    if (rst) begin
      occ = 0; wr_n = 0; rd_n = 0; rv_m = 0; ovf_m = 0; unf_m = 0;
    end else begin
      if (push && occ == DEPTH) ovf_m = 1;
      else if (clr_err)         ovf_m = 0;
      if (pop && occ == 0)      unf_m = 1;
      else if (clr_err)         unf_m = 0;
      wr_n += w;
      rd_n += rd;
      occ  += w - rd;
      rv_m  = rd;
    end
    @(negedge clk);
  endtask

  initial begin
    int mode;
    logic p, q, r, c;

    // r p q c | cnt wa ra | wen ren rv | full empty af ae ovf unf
    tbl.push_back(mk(0,1,0,0, 0,0,0, 1,0,0, 0,1,0,1,0,0));
    tbl.push_back(mk(0,1,0,0, 1,1,0, 1,0,0, 0,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,0, 2,2,0, 1,0,0, 0,0,0,1,0,0));
    tbl.push_back(mk(0,1,0,0, 3,3,0, 1,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 4,4,0, 1,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 5,5,0, 1,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0,0, 6,6,0, 1,0,0, 0,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,0, 7,7,0, 1,0,0, 0,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,0, 8,0,0, 0,0,0, 1,0,1,0,0,0));
    tbl.push_back(mk(0,0,0,0, 8,0,0, 0,0,0, 1,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,0, 8,0,0, 0,0,0, 1,0,1,0,1,0));
    tbl.push_back(mk(0,0,0,1, 8,0,0, 0,0,0, 1,0,1,0,1,0));
    tbl.push_back(mk(0,0,1,0, 8,0,0, 0,1,0, 1,0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 7,0,1, 0,1,1, 0,0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 6,0,2, 0,1,1, 0,0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0, 5,0,3, 0,1,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 4,0,4, 0,1,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 3,0,5, 0,1,1, 0,0,0,0,0,0));
    tbl.push_back(mk(0,0,1,0, 2,0,6, 0,1,1, 0,0,0,1,0,0));
    tbl.push_back(mk(0,0,1,0, 1,0,7, 0,1,1, 0,0,0,1,0,0));
    tbl.push_back(mk(0,1,1,0, 0,0,0, 1,0,1, 0,1,0,1,0,0));
    tbl.push_back(mk(0,0,0,0, 1,1,0, 0,0,0, 0,0,0,1,0,1));
    tbl.push_back(mk(1,1,1,0, 1,1,0, 1,1,0, 0,0,0,1,0,1));
    tbl.push_back(mk(0,0,0,0, 0,0,0, 0,0,0, 0,1,0,1,0,0));

    rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    @(negedge clk);

    foreach (tbl[i]) begin
      apply(tbl[i].rst, tbl[i].push, tbl[i].pop, tbl[i].clr);
      chk($sformatf("v%0d_count", i),  32'(count),        tbl[i].cnt);
      chk($sformatf("v%0d_waddr", i),  32'(waddr),        tbl[i].wa);
      chk($sformatf("v%0d_raddr", i),  32'(raddr),        tbl[i].ra);
      chk($sformatf("v%0d_wen", i),    32'(wen),          tbl[i].wen);
      chk($sformatf("v%0d_ren", i),    32'(ren),          tbl[i].ren);
      chk($sformatf("v%0d_rvalid", i), 32'(rvalid),       tbl[i].rv);
      chk($sformatf("v%0d_full", i),   32'(full),         tbl[i].full);
      chk($sformatf("v%0d_empty", i),  32'(empty),        tbl[i].empty);
      chk($sformatf("v%0d_afull", i),  32'(almost_full),  tbl[i].af);
      chk($sformatf("v%0d_aempty", i), 32'(almost_empty), tbl[i].ae);
      chk($sformatf("v%0d_ovf", i),    32'(overflow),     tbl[i].ovf);
      chk($sformatf("v%0d_unf", i),    32'(underflow),    tbl[i].unf);
      advance();
    end

    // Fill to 5, then streaming push+pop across the pointer wrap.
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 0);
      advance();
    end
    for (int i = 0; i < 20; i++) begin
      apply(0, 1, 1, 0);
      chk("pp_count", 32'(count), 5);
      if (i > 0) chk("pp_rvalid", 32'(rvalid), 1);
      advance();
    end

    // Set underflow, fill to 4, then reset with push and pop both high.
    apply(1, 0, 0, 0);
    advance();
    apply(0, 0, 1, 0);
    advance();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 0, 0);
      advance();
    end
    apply(1, 1, 1, 0);
    advance();
    apply(0, 0, 0, 0);
    chk("rs_count",  32'(count),     0);
    chk("rs_empty",  32'(empty),     1);
    chk("rs_rvalid", 32'(rvalid),    0);
    chk("rs_waddr",  32'(waddr),     0);
    chk("rs_raddr",  32'(raddr),     0);
    chk("rs_ovf",    32'(overflow),  0);
    chk("rs_unf",    32'(underflow), 0);
    advance();

    // Randomized traffic with fill-biased, drain-biased and balanced phases.
    mode = 0;
    for (int i = 0; i < 2000; i++) begin
      if (i % 64 == 0) mode = int'($urandom_range(0, 2));
      case (mode)
        0:       begin p = ($urandom_range(0, 99) < 80); q = ($urandom_range(0, 99) < 25); end
        1:       begin p = ($urandom_range(0, 99) < 25); q = ($urandom_range(0, 99) < 80); end
        default: begin p = ($urandom_range(0, 1) == 1); q = ($urandom_range(0, 1) == 1); end
      endcase
      r = ($urandom_range(0, 149) == 0);
      c = ($urandom_range(0, 7) == 0);
      apply(r, p, q, c);
      advance();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
